// File: rtl/itim_pkg.sv
// Shared ITIM constants and arbiter FSM state encoding.
package itim_pkg;
  localparam int ITIM_ADDR_W = 12;
  localparam int ITIM_DATA_W = 64;
  localparam int ITIM_MASK_W = ITIM_DATA_W / 8;

  typedef enum logic {
    IDLE      = 1'b0,
    RMW_MERGE = 1'b1
  } itim_state_e;
endpackage

// File: rtl/itim_byte_merge.sv
// Per-byte merge of SRAM read data with write data under a byte mask.
// Purely combinational.
module itim_byte_merge
  import itim_pkg::*;
#(
  parameter int DATA_W = ITIM_DATA_W
) (
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] mask_i,
  output logic [DATA_W-1:0]   merged_o
);
  for (genvar b = 0; b < DATA_W / 8; b++) begin : g_byte
    assign merged_o[b*8 +: 8] = mask_i[b] ? wdata_i[b*8 +: 8] : rdata_i[b*8 +: 8];
  end
endmodule

// File: rtl/itim_port_arbiter.sv
// Single-port ITIM arbiter: fetch has priority, slave partial writes run as read-modify-write.
// Optional slave anti-starvation counter enabled by macro ITIM_ARB_ANTISTARVE_EN.
module itim_port_arbiter
  import itim_pkg::*;
#(
  parameter int ADDR_W       = ITIM_ADDR_W,
  parameter int DATA_W       = ITIM_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fetch_req_valid,
  output logic                fetch_req_ready,
  input  logic [ADDR_W-1:0]   fetch_req_addr,
  output logic                fetch_resp_valid,
  output logic [DATA_W-1:0]   fetch_resp_data,
  input  logic                slave_req_valid,
  output logic                slave_req_ready,
  input  logic                slave_req_write,
  input  logic [ADDR_W-1:0]   slave_req_addr,
  input  logic [DATA_W-1:0]   slave_req_wdata,
  input  logic [DATA_W/8-1:0] slave_req_mask,
  output logic                slave_resp_valid,
  input  logic                slave_resp_ready,
  output logic [DATA_W-1:0]   slave_resp_data,
  output logic                sram_en,
  output logic                sram_wmode,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);
  localparam int MASK_W = DATA_W / 8;

  itim_state_e       state_q, state_d;
  logic              sl_busy_q, sl_busy_d;
  logic              rd_cap_q, rd_cap_d;
  logic              fresp_vld_q;
  logic              sresp_vld_q, sresp_vld_d;
  logic [DATA_W-1:0] sresp_dat_q, sresp_dat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] merged;
  logic              idle, starve_win, fetch_gnt, slave_gnt;
  logic              mask_full, mask_zero;

  assign idle            = (state_q == IDLE) && !reset;
  assign fetch_req_ready = idle && !starve_win;
  assign fetch_gnt       = fetch_req_ready && fetch_req_valid;
  assign slave_req_ready = idle && !sl_busy_q && (!fetch_req_valid || starve_win);
  assign slave_gnt       = slave_req_ready && slave_req_valid;
  assign mask_full       = &slave_req_mask;
  assign mask_zero       = ~|slave_req_mask;

`ifdef ITIM_ARB_ANTISTARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  // Counts only cycles where fetch, not our own outstanding transaction, blocks the slave.
  assign starve_win = (starve_q == CNT_W'(STARVE_LIMIT)) && slave_req_valid && !sl_busy_q;

  always_comb begin
    starve_d = starve_q;
    if (slave_gnt) begin
      starve_d = '0;
    end else if (slave_req_valid && !sl_busy_q && fetch_gnt &&
                 (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign starve_win = 1'b0;
`endif

  itim_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .rdata_i (sram_rdata),
    .wdata_i (wdata_q),
    .mask_i  (mask_q),
    .merged_o(merged)
  );

  always_comb begin
    state_d     = state_q;
    sl_busy_d   = sl_busy_q;
    rd_cap_d    = 1'b0;
    sresp_vld_d = sresp_vld_q;
    sresp_dat_d = sresp_dat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    sram_en     = 1'b0;
    sram_wmode  = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;

    if (sresp_vld_q && slave_resp_ready) begin
      sresp_vld_d = 1'b0;
      sl_busy_d   = 1'b0;
    end
    if (rd_cap_q) begin
      sresp_vld_d = 1'b1;
      sresp_dat_d = sram_rdata;
    end

    case (state_q)
      IDLE: begin
        if (fetch_gnt) begin
          sram_en   = 1'b1;
          sram_addr = fetch_req_addr;
        end else if (slave_gnt) begin
          sl_busy_d = 1'b1;
          sram_addr = slave_req_addr;
          if (!slave_req_write) begin
            sram_en  = 1'b1;
            rd_cap_d = 1'b1;
          end else if (mask_full) begin
            sram_en     = 1'b1;
            sram_wmode  = 1'b1;
            sram_wdata  = slave_req_wdata;
            sresp_vld_d = 1'b1;
            sresp_dat_d = '0;
          end else if (mask_zero) begin
            sresp_vld_d = 1'b1;
            sresp_dat_d = '0;
          end else begin
            // Partial mask: read the old word now, merge and write it back next cycle.
            sram_en = 1'b1;
            addr_d  = slave_req_addr;
            wdata_d = slave_req_wdata;
            mask_d  = slave_req_mask;
            state_d = RMW_MERGE;
          end
        end
      end
      RMW_MERGE: begin
        sram_en     = 1'b1;
        sram_wmode  = 1'b1;
        sram_addr   = addr_q;
        sram_wdata  = merged;
        sresp_vld_d = 1'b1;
        sresp_dat_d = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sl_busy_q   <= 1'b0;
      rd_cap_q    <= 1'b0;
      fresp_vld_q <= 1'b0;
      sresp_vld_q <= 1'b0;
      sresp_dat_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      sl_busy_q   <= sl_busy_d;
      rd_cap_q    <= rd_cap_d;
      fresp_vld_q <= fetch_gnt;
      sresp_vld_q <= sresp_vld_d;
      sresp_dat_q <= sresp_dat_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
    end
  end

  assign fetch_resp_valid = fresp_vld_q;
  assign fetch_resp_data  = sram_rdata;
  assign slave_resp_valid = sresp_vld_q;
  assign slave_resp_data  = sresp_dat_q;
endmodule

// File: tb/tb_itim_port_arbiter.sv
// Bench for itim_port_arbiter: behavioural SRAM, reference memory image, directed and random steps.
module tb_itim_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int MW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          fetch_req_valid, fetch_req_ready;
  logic [AW-1:0] fetch_req_addr;
  logic          fetch_resp_valid;
  logic [DW-1:0] fetch_resp_data;
  logic          slave_req_valid, slave_req_ready, slave_req_write;
  logic [AW-1:0] slave_req_addr;
  logic [DW-1:0] slave_req_wdata;
  logic [MW-1:0] slave_req_mask;
  logic          slave_resp_valid, slave_resp_ready;
  logic [DW-1:0] slave_resp_data;
  logic          sram_en, sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  int checks = 0;
  int errors = 0;

  itim_port_arbiter dut (
    .clock(clock), .reset(reset),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_req_addr(fetch_req_addr), .fetch_resp_valid(fetch_resp_valid),
    .fetch_resp_data(fetch_resp_data),
    .slave_req_valid(slave_req_valid), .slave_req_ready(slave_req_ready),
    .slave_req_write(slave_req_write), .slave_req_addr(slave_req_addr),
    .slave_req_wdata(slave_req_wdata), .slave_req_mask(slave_req_mask),
    .slave_resp_valid(slave_resp_valid), .slave_resp_ready(slave_resp_ready),
    .slave_resp_data(slave_resp_data),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= sram_wdata;
      else            sram_rdata <= mem[sram_addr];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] apply_mask(input logic [63:0] old, input logic [63:0] wd,
                                             input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic slave_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [MW-1:0] m, output logic [DW-1:0] rd, output int lat);
    int n;
    slave_req_valid = 1'b1; slave_req_write = wr; slave_req_addr = a;
    slave_req_wdata = wd; slave_req_mask = m; slave_resp_ready = 1'b1;
    n = 0;
    @(negedge clock);
    while (!slave_req_ready && n < 50) begin
      step(); n++; @(negedge clock);
    end
    if (!slave_req_ready) begin
      slave_req_valid = 1'b0; rd = '0; lat = -1;
      step();
      return;
    end
    step();
    slave_req_valid = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!slave_resp_valid && lat < 50) begin
      step(); lat++; @(negedge clock);
    end
    rd = slave_resp_data;
    step();
  endtask

  task automatic fetch_one(input logic [AW-1:0] a);
    fetch_req_valid = 1'b1; fetch_req_addr = a;
    @(negedge clock);
    chk("rnd_fetch_rdy", fetch_req_ready, 1'b1);
    step();
    fetch_req_valid = 1'b0;
    @(negedge clock);
    chk("rnd_fetch_vld", fetch_resp_valid, 1'b1);
    chk("rnd_fetch_dat", fetch_resp_data, ref_mem[a]);
    step();
  endtask

  initial begin
    logic [AW-1:0] fa [0:2];
    logic [DW-1:0] rd, old_w, wd;
    logic [MW-1:0] m;
    logic [AW-1:0] a;
    int lat, gnt, got, exp_gnt, exp_frdy, fr_at_gnt;
    logic [DW-1:0] rdat;

    reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    fetch_req_valid = 1'b1; fetch_req_addr = '0;
    slave_req_valid = 1'b1; slave_req_write = 1'b0; slave_req_addr = '0;
    slave_req_wdata = '0; slave_req_mask = '0; slave_resp_ready = 1'b1;

    // Reset state, with requests asserted to show readies are held low.
    @(negedge clock);
    chk("rst_fetch_rdy", fetch_req_ready, 1'b0);
    chk("rst_slave_rdy", slave_req_ready, 1'b0);
    chk("rst_sram_en", sram_en, 1'b0);
    chk("rst_fetch_vld", fetch_resp_valid, 1'b0);
    chk("rst_slave_vld", slave_resp_valid, 1'b0);
    fetch_req_valid = 1'b0; slave_req_valid = 1'b0;
    step();
    for (int i = 0; i < 4096; i++) preload(AW'(i), {$urandom, $urandom});
    reset = 1'b0;
    @(negedge clock);
    chk("idle_fetch_rdy", fetch_req_ready, 1'b1);
    step();

    // Back-to-back fetches.
    fa[0] = 12'h000; fa[1] = 12'h001; fa[2] = 12'hFFF;
    for (int c = 0; c < 4; c++) begin
      fetch_req_valid = (c < 3);
      fetch_req_addr  = fa[(c < 3) ? c : 0];
      @(negedge clock);
      chk("f_sram_en", sram_en, (c < 3));
      if (c < 3) chk("f_sram_addr", sram_addr, fa[c]);
      if (c > 0) begin
        chk("f_resp_vld", fetch_resp_valid, 1'b1);
        chk("f_resp_dat", fetch_resp_data, ref_mem[fa[c-1]]);
      end else begin
        chk("f_resp_vld0", fetch_resp_valid, 1'b0);
      end
      step();
    end
    @(negedge clock);
    chk("f_resp_idle", fetch_resp_valid, 1'b0);
    step();

    // Full-mask write then read back.
    slave_txn(1'b1, 12'h010, 64'h1122334455667788, 8'hFF, rd, lat);
    ref_mem[12'h010] = 64'h1122334455667788;
    chk("wfull_lat", lat, 1);
    chk("wfull_ack", rd, 64'h0);
    slave_txn(1'b0, 12'h010, 64'h0, 8'h00, rd, lat);
    chk("rd_lat", lat, 2);
    chk("rd_dat", rd, 64'h1122334455667788);

    // Partial write sequenced as RMW, with a fetch waiting through the merge cycle.
    preload(12'h020, 64'hAAAAAAAAAAAAAAAA);
    slave_req_valid = 1'b1; slave_req_write = 1'b1; slave_req_addr = 12'h020;
    slave_req_wdata = 64'h5555555555555555; slave_req_mask = 8'h0F; slave_resp_ready = 1'b1;
    @(negedge clock);
    chk("rmw_gnt", slave_req_ready, 1'b1);
    chk("rmw_rd_en", sram_en, 1'b1);
    chk("rmw_rd_mode", sram_wmode, 1'b0);
    step();
    slave_req_valid = 1'b0; fetch_req_valid = 1'b1; fetch_req_addr = 12'h021;
    @(negedge clock);
    chk("rmw_fetch_rdy", fetch_req_ready, 1'b0);
    chk("rmw_wr_mode", sram_wmode, 1'b1);
    chk("rmw_wr_addr", sram_addr, 12'h020);
    chk("rmw_wr_dat", sram_wdata, 64'hAAAAAAAA55555555);
    chk("rmw_no_ack_yet", slave_resp_valid, 1'b0);
    step();
    @(negedge clock);
    chk("rmw_fetch_rdy2", fetch_req_ready, 1'b1);
    chk("rmw_ack_vld", slave_resp_valid, 1'b1);
    chk("rmw_ack_dat", slave_resp_data, 64'h0);
    step();
    fetch_req_valid = 1'b0;
    @(negedge clock);
    chk("rmw_fetch_dat", fetch_resp_data, ref_mem[12'h021]);
    step();
    ref_mem[12'h020] = apply_mask(64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 8'h0F);
    chk("rmw_mem", mem[12'h020], ref_mem[12'h020]);

    // Contention: fetch held for 20 cycles against a pending slave read.
`ifdef ITIM_ARB_ANTISTARVE_EN
    exp_gnt = 8; exp_frdy = 0;
`else
    exp_gnt = 20; exp_frdy = 1;
`endif
    gnt = -1; got = 0; rdat = '0; fr_at_gnt = -1;
    slave_req_valid = 1'b1; slave_req_write = 1'b0; slave_req_addr = 12'h030;
    slave_resp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      fetch_req_valid = (c < 20);
      fetch_req_addr  = AW'(c);
      @(negedge clock);
      if (gnt < 0 && slave_req_valid && slave_req_ready) begin
        gnt = c; fr_at_gnt = int'(fetch_req_ready);
      end
      if (slave_resp_valid && got == 0) begin
        got = 1; rdat = slave_resp_data;
      end
      step();
      if (gnt >= 0) slave_req_valid = 1'b0;
    end
    fetch_req_valid = 1'b0;
    chk("cont_gnt_cycle", gnt, exp_gnt);
    chk("cont_fetch_rdy", fr_at_gnt, exp_frdy);
    chk("cont_resp_got", got, 1);
    chk("cont_resp_dat", rdat, ref_mem[12'h030]);

    // Response backpressure: data held, slave blocked, fetch still served.
    slave_resp_ready = 1'b0;
    slave_req_valid = 1'b1; slave_req_write = 1'b0; slave_req_addr = 12'h040;
    @(negedge clock);
    chk("bp_gnt", slave_req_ready, 1'b1);
    step();
    slave_req_addr = 12'h041;
    @(negedge clock);
    chk("bp_busy_rdy", slave_req_ready, 1'b0);
    chk("bp_vld_early", slave_resp_valid, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      fetch_req_valid = 1'b1; fetch_req_addr = AW'(12'h050 + k);
      @(negedge clock);
      chk("bp_hold_vld", slave_resp_valid, 1'b1);
      chk("bp_hold_dat", slave_resp_data, ref_mem[12'h040]);
      chk("bp_slave_rdy", slave_req_ready, 1'b0);
      chk("bp_fetch_rdy", fetch_req_ready, 1'b1);
      if (k > 0) chk("bp_fetch_dat", fetch_resp_data, ref_mem[12'h050 + k - 1]);
      step();
    end
    fetch_req_valid = 1'b0; slave_resp_ready = 1'b1;
    @(negedge clock);
    chk("bp_hs_vld", slave_resp_valid, 1'b1);
    chk("bp_hs_rdy", slave_req_ready, 1'b0);
    chk("bp_last_fetch", fetch_resp_data, ref_mem[12'h054]);
    step();
    @(negedge clock);
    chk("bp_after_vld", slave_resp_valid, 1'b0);
    chk("bp_after_rdy", slave_req_ready, 1'b1);
    step();
    slave_req_valid = 1'b0;
    @(negedge clock);
    chk("bp2_vld_early", slave_resp_valid, 1'b0);
    step();
    @(negedge clock);
    chk("bp2_vld", slave_resp_valid, 1'b1);
    chk("bp2_dat", slave_resp_data, ref_mem[12'h041]);
    step();

    // Reset during the RMW write-back cycle.
    old_w = ref_mem[12'h060];
    slave_req_valid = 1'b1; slave_req_write = 1'b1; slave_req_addr = 12'h060;
    slave_req_wdata = {$urandom, $urandom}; slave_req_mask = 8'h3C;
    @(negedge clock);
    chk("rstrmw_gnt", slave_req_ready, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b1; slave_req_valid = 1'b0;
    @(negedge clock);
    chk("rstrmw_sram_en", sram_en, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("rstrmw_idle", fetch_req_ready, 1'b1);
    chk("rstrmw_slv_rdy", slave_req_ready, 1'b1);
    chk("rstrmw_no_ack", slave_resp_valid, 1'b0);
    chk("rstrmw_no_fvld", fetch_resp_valid, 1'b0);
    step();
    @(negedge clock);
    chk("rstrmw_no_ack2", slave_resp_valid, 1'b0);
    chk("rstrmw_mem", mem[12'h060], old_w);
    step();

    // Random mix of fetches, slave reads and slave writes over a small address window.
    for (int it = 0; it < 80; it++) begin
      a = AW'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: fetch_one(a);
        1: begin
          slave_txn(1'b0, a, 64'h0, 8'h00, rd, lat);
          chk("rnd_rd_lat", lat, 2);
          chk("rnd_rd_dat", rd, ref_mem[a]);
        end
        default: begin
          wd = {$urandom, $urandom};
          case ($urandom_range(0, 3))
            0:       m = 8'hFF;
            1:       m = 8'h00;
            default: m = MW'($urandom_range(0, 255));
          endcase
          slave_txn(1'b1, a, wd, m, rd, lat);
          ref_mem[a] = apply_mask(ref_mem[a], wd, m);
          chk("rnd_wr_lat", lat, (m == 8'hFF || m == 8'h00) ? 1 : 2);
          chk("rnd_wr_ack", rd, 64'h0);
        end
      endcase
    end
    for (int i = 0; i < 16; i++) chk("rnd_mem_image", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
